// File: rtl/tmr_pkg.sv
// Shared encodings and prescaler helpers for the compare-match timer channel.
package tmr_pkg;

  localparam int PRE_W = 10;

  typedef enum logic [2:0] {
    CKS_STOP    = 3'b000,
    CKS_DIV2    = 3'b001,
    CKS_DIV8    = 3'b010,
    CKS_DIV32   = 3'b011,
    CKS_DIV64   = 3'b100,
    CKS_DIV1024 = 3'b101,
    CKS_EXT     = 3'b110,
    CKS_HALT    = 3'b111
  } cks_e;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_e;

  typedef enum logic [1:0] {
    CCLR_NONE    = 2'b00,
    CCLR_MATCH_A = 2'b01,
    CCLR_MATCH_B = 2'b10,
    CCLR_TMRI    = 2'b11
  } cclr_e;

  typedef enum logic [1:0] {
    OS_NONE   = 2'b00,
    OS_LOW    = 2'b01,
    OS_HIGH   = 2'b10,
    OS_TOGGLE = 2'b11
  } os_e;

  // Low prescaler bits that must all be ones for a divided tick.
  function automatic logic [PRE_W-1:0] pre_mask(input logic [2:0] sel);
    case (sel)
      CKS_DIV2:    pre_mask = 10'h001;
      CKS_DIV8:    pre_mask = 10'h007;
      CKS_DIV32:   pre_mask = 10'h01F;
      CKS_DIV64:   pre_mask = 10'h03F;
      CKS_DIV1024: pre_mask = 10'h3FF;
      default:     pre_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/tmr_edge_sync.sv
// Two-flop synchroniser plus edge register; pulses on the selected edge(s).
module tmr_edge_sync
  import tmr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [1:0] sel,
  output logic       pulse
);

  // sh[0], sh[1]: synchroniser; sh[2]: previous synchronised value
  logic [2:0] sh;
  logic       rise;
  logic       fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], din};
  end

  assign rise  = sh[1] & ~sh[2];
  assign fall  = ~sh[1] & sh[2];
  assign pulse = (sel[0] & rise) | (sel[1] & fall);

endmodule

// File: rtl/tmr_channel_x.sv
// Compare-match timer channel: prescaled or external count, two compares,
// clear modes, TMO pin actions and one-cycle interrupt pulses.
module tmr_channel_x
  import tmr_pkg::*;
#(
  parameter int BIT_WIDTH             = 8,
  parameter int CLK_SELECT_BIT_WIDTH  = 3,
  parameter int EDGE_SELECT_BIT_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             TMCI,
  input  logic                             TMRI,
  input  logic [CLK_SELECT_BIT_WIDTH-1:0]  cks,
  input  logic [EDGE_SELECT_BIT_WIDTH-1:0] edge_sel,
  input  logic [1:0]                       cclr,
  input  logic [1:0]                       os_a,
  input  logic [1:0]                       os_b,
  input  logic [BIT_WIDTH-1:0]             tcora,
  input  logic [BIT_WIDTH-1:0]             tcorb,
  input  logic                             wr_tcnt,
  input  logic [BIT_WIDTH-1:0]             wr_data,
  output logic [BIT_WIDTH-1:0]             tcnt,
  output logic                             TMO,
  output logic                             CMIA,
  output logic                             CMIB,
  output logic                             OVI,
  output logic                             ADC_REQUEST
);

  cks_e                 cks_v;
  logic [PRE_W-1:0]     pre;
  logic                 ext_tick;
  logic                 tmri_edge;
  logic                 tick;
  logic                 match_a;
  logic                 match_b;
  logic                 clr_tmri;
  logic                 clr_match;
  logic [BIT_WIDTH-1:0] tcnt_next;
  logic                 ovi_next;
  logic                 tmo_next;
  logic                 act_tog;
  logic                 act_hi;
  logic                 act_lo;

  assign cks_v = cks_e'(3'(cks));

  tmr_edge_sync u_tmci_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (TMCI),
    .sel   (2'(edge_sel)),
    .pulse (ext_tick)
  );

  tmr_edge_sync u_tmri_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (TMRI),
    .sel   (EDGE_RISE),
    .pulse (tmri_edge)
  );

  // The prescaler never restarts on a cks change; the tick is decoded
  // from its free-running value so a new divider only fires on its own boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre <= '0;
    else     pre <= pre + PRE_W'(1);
  end

  always_comb begin
    case (cks_v)
      CKS_EXT:            tick = ext_tick;
      CKS_STOP, CKS_HALT: tick = 1'b0;
      default:            tick = &(pre | ~pre_mask(cks_v));
    endcase
  end

  assign match_a   = tick && (tcnt == tcora);
  assign match_b   = tick && (tcnt == tcorb);
  assign clr_tmri  = (cclr == CCLR_TMRI) && tmri_edge;
  assign clr_match = ((cclr == CCLR_MATCH_A) && match_a) ||
                     ((cclr == CCLR_MATCH_B) && match_b);

  always_comb begin
    tcnt_next = tcnt;
    ovi_next  = 1'b0;
    if (wr_tcnt) begin
      tcnt_next = wr_data;
    end else if (clr_tmri || clr_match) begin
      tcnt_next = '0;
    end else if (tick) begin
      tcnt_next = tcnt + BIT_WIDTH'(1);
      ovi_next  = &tcnt;
    end
  end

  // Simultaneous A/B actions: toggle beats drive-high beats drive-low.
  always_comb begin
    act_tog  = (match_a && os_a == OS_TOGGLE) || (match_b && os_b == OS_TOGGLE);
    act_hi   = (match_a && os_a == OS_HIGH)   || (match_b && os_b == OS_HIGH);
    act_lo   = (match_a && os_a == OS_LOW)    || (match_b && os_b == OS_LOW);
    tmo_next = TMO;
    if (act_tog)     tmo_next = ~TMO;
    else if (act_hi) tmo_next = 1'b1;
    else if (act_lo) tmo_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt        <= '0;
      TMO         <= 1'b0;
      CMIA        <= 1'b0;
      CMIB        <= 1'b0;
      OVI         <= 1'b0;
      ADC_REQUEST <= 1'b0;
    end else begin
      tcnt        <= tcnt_next;
      TMO         <= tmo_next;
      CMIA        <= match_a;
      CMIB        <= match_b;
      OVI         <= ovi_next;
      ADC_REQUEST <= match_a;
    end
  end

endmodule

// File: tb/tb_tmr_channel_x.sv
// Scoreboard bench for tmr_channel_x: a cycle-level reference model predicts
// outputs into a queue, a monitor compares them one cycle later.
module tb_tmr_channel_x;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       TMCI = 1'b0;
  logic       TMRI = 1'b0;
  logic [2:0] cks = 3'd0;
  logic [1:0] edge_sel = 2'd0;
  logic [1:0] cclr = 2'd0;
  logic [1:0] os_a = 2'd0;
  logic [1:0] os_b = 2'd0;
  logic [7:0] tcora = 8'd0;
  logic [7:0] tcorb = 8'd0;
  logic       wr_tcnt = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] tcnt;
  logic       TMO, CMIA, CMIB, OVI, ADC_REQUEST;

  tmr_channel_x dut (
    .clk(clk), .rst(rst), .TMCI(TMCI), .TMRI(TMRI), .cks(cks), .edge_sel(edge_sel),
    .cclr(cclr), .os_a(os_a), .os_b(os_b), .tcora(tcora), .tcorb(tcorb),
    .wr_tcnt(wr_tcnt), .wr_data(wr_data), .tcnt(tcnt), .TMO(TMO), .CMIA(CMIA),
    .CMIB(CMIB), .OVI(OVI), .ADC_REQUEST(ADC_REQUEST)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tmo;
    logic       cmia;
    logic       cmib;
    logic       ovi;
    logic       adc;
  } obs_t;

  obs_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: clk cycles since reset, count, pin, and the
  // sampled TMCI/TMRI history (index 0 = most recent sample).
  int unsigned m_cyc = 0;
  logic [7:0]  m_cnt = 8'd0;
  logic        m_tmo = 1'b0;
  logic [2:0]  ci_h  = 3'd0;
  logic [2:0]  ri_h  = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic bit ext_edge(input logic [2:0] h, input logic [1:0] sel);
    bit r, f;
    r = h[1] && !h[2];
    f = !h[1] && h[2];
    return (sel[0] && r) || (sel[1] && f);
  endfunction

  // Predict the state after the coming rising edge from current inputs.
  task automatic predict();
    int   div;
    bit   tick, ma, mb, tog, hi, lo;
    obs_t e;
    case (cks)
      3'd1: div = 2;
      3'd2: div = 8;
      3'd3: div = 32;
      3'd4: div = 64;
      3'd5: div = 1024;
      default: div = 0;
    endcase
    if (div != 0)        tick = (m_cyc % div) == div - 1;
    else if (cks == 3'd6) tick = ext_edge(ci_h, edge_sel);
    else                 tick = 1'b0;
    ma = tick && (m_cnt == tcora);
    mb = tick && (m_cnt == tcorb);
    e = '0;
    e.cmia = ma;
    e.cmib = mb;
    e.adc  = ma;
    if (wr_tcnt)                                   e.cnt = wr_data;
    else if (cclr == 2'd3 && ext_edge(ri_h, 2'd1)) e.cnt = 8'd0;
    else if ((cclr == 2'd1 && ma) || (cclr == 2'd2 && mb)) e.cnt = 8'd0;
    else if (tick) begin
      e.cnt = (m_cnt == 8'd255) ? 8'd0 : m_cnt + 8'd1;
      e.ovi = (m_cnt == 8'd255);
    end else e.cnt = m_cnt;
    tog = (ma && os_a == 2'd3) || (mb && os_b == 2'd3);
    hi  = (ma && os_a == 2'd2) || (mb && os_b == 2'd2);
    lo  = (ma && os_a == 2'd1) || (mb && os_b == 2'd1);
    e.tmo = tog ? !m_tmo : hi ? 1'b1 : lo ? 1'b0 : m_tmo;
    m_cnt = e.cnt;
    m_tmo = e.tmo;
    m_cyc = (m_cyc + 1) % 1024;
    ci_h  = {ci_h[1:0], TMCI};
    ri_h  = {ri_h[1:0], TMRI};
    sbq.push_back(e);
  endtask

  task automatic cycle();
    predict();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc = 0; m_cnt = 8'd0; m_tmo = 1'b0; ci_h = 3'd0; ri_h = 3'd0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        a = {tcnt, TMO, CMIA, CMIB, OVI, ADC_REQUEST};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got cnt=%0h tmo=%b cmia=%b cmib=%b ovi=%b adc=%b, required cnt=%0h tmo=%b cmia=%b cmib=%b ovi=%b adc=%b",
                   $time, a.cnt, a.tmo, a.cmia, a.cmib, a.ovi, a.adc,
                   e.cnt, e.tmo, e.cmia, e.cmib, e.ovi, e.adc);
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n_ovi, n_cmia, n_cmib_with_a;
    @(posedge clk); #2;
    do_reset();
    check("reset_state", {tcnt, TMO, CMIA, CMIB, OVI, ADC_REQUEST}, 32'd0);

    // Divide-by-2, clear on A=3, toggle TMO: 8-clk period.
    cks = 3'd1; tcora = 8'd3; tcorb = 8'd99; cclr = 2'd1; os_a = 2'd3; os_b = 2'd0;
    n_cmia = 0;
    repeat (40) begin
      cycle();
      n_cmia += int'(CMIA);
    end
    check("cmia_per_period", n_cmia, 5);

    // Wrap from 255 to 0 with a single OVI and no CMIA at tcora=200.
    cclr = 2'd0; tcora = 8'd200; wr_data = 8'd250; wr_tcnt = 1'b1;
    cycle();
    wr_tcnt = 1'b0;
    n_ovi = 0; n_cmia = 0;
    repeat (20) begin
      cycle();
      n_ovi  += int'(OVI);
      n_cmia += int'(CMIA);
    end
    check("ovi_single_pulse", n_ovi, 1);
    check("no_cmia_at_wrap", n_cmia, 0);

    // External count on both TMCI edges, toggled every 10 clk.
    cks = 3'd6; edge_sel = 2'd3; wr_data = 8'd0; wr_tcnt = 1'b1;
    cycle();
    wr_tcnt = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) TMCI = ~TMCI;
      cycle();
    end
    check("ext_edge_count", tcnt, 8'd10);

    // Equal compares: toggle on B beats drive-low on A.
    cks = 3'd1; edge_sel = 2'd0; tcora = 8'd5; tcorb = 8'd5; cclr = 2'd1;
    os_a = 2'd1; os_b = 2'd3; wr_data = 8'd0; wr_tcnt = 1'b1;
    cycle();
    wr_tcnt = 1'b0;
    n_cmia = 0; n_cmib_with_a = 0;
    repeat (48) begin
      cycle();
      n_cmia += int'(CMIA);
      n_cmib_with_a += int'(CMIA && CMIB);
    end
    check("cmia_cmib_together", n_cmib_with_a, n_cmia);
    check("cmia_count_equal_ab", n_cmia, 4);

    // TMRI clear coinciding with a software write: the write wins.
    cclr = 2'd3; tcora = 8'd250; tcorb = 8'd250; os_a = 2'd0; os_b = 2'd0;
    wr_data = 8'h40;
    while (m_cyc % 2 != 1) cycle();
    TMRI = 1'b1;
    cycle();
    TMRI = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_tcnt = ext_edge(ri_h, 2'd1);
      cycle();
      if (wr_tcnt) check("wr_beats_tmri", tcnt, 8'h40);
      wr_tcnt = 1'b0;
    end
    repeat (6) cycle();
    TMRI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i == 2) check("tmri_clears", tcnt, 8'd0);
    end
    TMRI = 1'b0;
    cycle();

    // Asynchronous reset while counting at 0x7F.
    cks = 3'd0; cclr = 2'd0; wr_data = 8'h7F; wr_tcnt = 1'b1;
    cycle();
    wr_tcnt = 1'b0;
    check("held_at_7f", tcnt, 8'h7F);
    cks = 3'd1;
    #3 rst = 1'b1;
    #1 check("async_reset_outputs", {tcnt, TMO, CMIA, CMIB, OVI, ADC_REQUEST}, 32'd0);
    do_reset();

    // Randomised configurations, including mid-count cks changes.
    for (int s = 0; s < 40; s++) begin
      cks      = 3'($urandom_range(0, 7));
      edge_sel = 2'($urandom_range(0, 3));
      cclr     = 2'($urandom_range(0, 3));
      os_a     = 2'($urandom_range(0, 3));
      os_b     = 2'($urandom_range(0, 3));
      tcora    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      tcorb    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) do_reset();
      repeat ($urandom_range(30, 150)) begin
        if ($urandom_range(0, 5) == 0) TMCI = ~TMCI;
        if ($urandom_range(0, 7) == 0) TMRI = ~TMRI;
        wr_tcnt = ($urandom_range(0, 30) == 0);
        wr_data = 8'($urandom);
        cycle();
      end
      wr_tcnt = 1'b0;
    end

    @(posedge clk); #2;
    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr_channel_x.md
TMR_CHANNEL_X -- requirements
Module: tmr_channel_x

Interface
REQ-001 Parameter BIT_WIDTH, 8, counter/compare width; legal range 8..32.
REQ-002 Parameter CLK_SELECT_BIT_WIDTH, 3, width of clock-select field.
REQ-003 Parameter EDGE_SELECT_BIT_WIDTH, 2, width of external-edge-select field.
REQ-004 Clock and reset: single clock clk; reset is asynchronous and active-high, port rst.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 TMCI  in  1  external count clock, asynchronous to clk.
REQ-008 TMRI  in  1  external counter reset, asynchronous to clk.
REQ-009 cks  in  CLK_SELECT_BIT_WIDTH  count source select.
REQ-010 edge_sel  in  EDGE_SELECT_BIT_WIDTH  TMCI edge select.
REQ-011 cclr  in  2  clear mode: 00 none, 01 match A, 10 match B, 11 TMRI rising edge.
REQ-012 os_a, os_b  in  2 each  TMO action on match A/B: 00 none, 01 drive 0, 10 drive 1, 11 toggle.
REQ-013 tcora, tcorb  in  BIT_WIDTH each  compare values.
REQ-014 wr_tcnt  in  1  one-cycle software write strobe; wr_data  in  BIT_WIDTH  write value.
REQ-015 tcnt  out  BIT_WIDTH  current count.
REQ-016 TMO  out  1  compare-match output pin.
REQ-017 CMIA, CMIB, OVI  out  1 each  one-cycle interrupt pulses.
REQ-018 ADC_REQUEST  out  1  one-cycle pulse on match A.

Function
REQ-019 Prescaler: free-running 10-bit counter; tick when low k+1 bits are all ones: cks 001 clk/2, 010 clk/8, 011 clk/32, 100 clk/64, 101 clk/1024.
REQ-020 cks 000 or 111 stops counting; cks 110 selects external TMCI edges.
REQ-021 TMCI and TMRI each pass a 2-FF synchroniser plus edge register; tick/clear reaches tcnt exactly 3 clk after input edge.
REQ-022 edge_sel: 00 none, 01 rising, 10 falling, 11 both edges.
REQ-023 On a tick, compare uses the pre-increment tcnt; tcnt==tcora is match A, tcnt==tcorb is match B.
REQ-024 Next-state priority: wr_tcnt > TMRI clear (cclr=11) > match clear (cclr 01/10, on tick) > increment (on tick) > hold.
REQ-025 Increment wraps all-ones to 0 and pulses OVI the next cycle; no OVI when the tick clears instead.
REQ-026 CMIA/CMIB/ADC_REQUEST pulse one cycle after the matching tick, even if wr_tcnt overrides tcnt that cycle.
REQ-027 TMO updates the cycle after a match; simultaneous A and B matches resolve toggle > drive 1 > drive 0.
REQ-028 Changing cks mid-count neither resets the prescaler nor generates a spurious tick.

Reset
REQ-029 rst clears tcnt, prescaler, synchronisers and edge registers to 0; TMO, CMIA, CMIB, OVI and ADC_REQUEST to 0.
REQ-030 The first tick after rst release occurs at the earliest at the normal prescaler boundary.

Structure
REQ-031 Package tmr_pkg holds cks, edge_sel, cclr and os encodings and prescaler-width constant.
REQ-032 Sub-module tmr_edge_sync (2-FF sync plus rise/fall detect) is instantiated for TMCI and TMRI.

Verification
REQ-033 cks=001, tcora=3, cclr=01, os_a=11 -> tcnt counts 0..3 and clears; TMO toggles each 8 clk; CMIA and ADC_REQUEST pulse once per period.
REQ-034 BIT_WIDTH=8, cks=001, cclr=00 -> tcnt 255 to 0 wrap, OVI single pulse; no CMIA with tcora=200 at wrap.
REQ-035 cks=110, edge_sel=11, TMCI toggling every 10 clk -> tcnt +1 per TMCI edge, 3 clk latency.
REQ-036 tcora=tcorb=5, os_a=01, os_b=11 -> TMO toggles (toggle wins); CMIA and CMIB pulse same cycle.
REQ-037 cclr=11, TMRI pulse while ticking, wr_tcnt=0x40 same cycle as tick -> wr wins: tcnt=0x40; later TMRI edge clears tcnt to 0.
REQ-038 rst asserted mid-count at tcnt=0x7F -> all outputs 0 immediately, asynchronously.
